// File: rtl/p2p_tx_arbiter_pkg.sv
// Shared types and helpers for the point-to-point transmit arbiter.
package p2p_tx_arb_pkg;

  typedef enum logic {IDLE, BUSY} state_e;

  localparam int STAT_W = 16;

  function automatic int src_width(input int n);
    return (n > 2) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/p2p_tx_arbiter_if.sv
// Requester and link bundle of the transmit arbiter; slave = arbiter side.
// Stats signals exist only when P2P_TX_ARB_STATS_EN is defined.
interface p2p_tx_arbiter_if import p2p_tx_arb_pkg::*; #(
  parameter int N_REQ = 4,
  parameter int WIDTH = 8,
  parameter int SRC_W = src_width(N_REQ)
);
  logic [N_REQ-1:0]       req_valid;
  logic [N_REQ*WIDTH-1:0] req_data;
  logic [N_REQ-1:0]       req_last;
  logic [N_REQ-1:0]       req_ready;
  logic                   link_valid;
  logic [WIDTH-1:0]       link_data;
  logic                   link_last;
  logic [SRC_W-1:0]       link_src;
  logic                   link_ready;
`ifdef P2P_TX_ARB_STATS_EN
  logic                    stat_clear;
  logic [N_REQ*STAT_W-1:0] stat_words;
`endif

  modport master (
    output req_valid, req_data, req_last, link_ready,
    input  req_ready, link_valid, link_data, link_last, link_src
`ifdef P2P_TX_ARB_STATS_EN
    , output stat_clear, input stat_words
`endif
  );

  modport slave (
    input  req_valid, req_data, req_last, link_ready,
    output req_ready, link_valid, link_data, link_last, link_src
`ifdef P2P_TX_ARB_STATS_EN
    , input stat_clear, output stat_words
`endif
  );
endinterface

// File: rtl/p2p_tx_arbiter_rr_pick.sv
// Combinational round-robin picker: first request strictly after i_ptr, with wrap.
module rr_pick #(
  parameter int N  = 4,
  parameter int SW = 2
) (
  input  logic [N-1:0]  i_req,
  input  logic [SW-1:0] i_ptr,
  output logic [N-1:0]  o_gnt_oh,
  output logic [SW-1:0] o_gnt_idx
);
  int w_j;

  // Walk from farthest to nearest so the nearest hit is the last write.
  always_comb begin
    o_gnt_oh  = '0;
    o_gnt_idx = '0;
    w_j       = 0;
    for (int k = N; k >= 1; k--) begin
      w_j = (int'(i_ptr) + k) % N;
      if (i_req[w_j]) begin
        o_gnt_oh      = '0;
        o_gnt_oh[w_j] = 1'b1;
        o_gnt_idx     = SW'(w_j);
      end
    end
  end
endmodule

// File: rtl/p2p_tx_arbiter.sv
// Per-packet round-robin arbiter feeding one registered link output.
// Optional per-requester word counters under P2P_TX_ARB_STATS_EN.
module p2p_tx_arbiter import p2p_tx_arb_pkg::*; #(
  parameter int N_REQ = 4,
  parameter int WIDTH = 8,
  parameter int SRC_W = src_width(N_REQ)
) (
  input logic             clock,
  input logic             reset,
  p2p_tx_arbiter_if.slave bus
);
  state_e           r_state;
  logic [SRC_W-1:0] r_ptr;
  logic [SRC_W-1:0] r_grant;
  logic             r_link_valid;
  logic [WIDTH-1:0] r_link_data;
  logic             r_link_last;
  logic [SRC_W-1:0] r_link_src;

  logic [N_REQ-1:0] w_gnt_oh;
  logic [SRC_W-1:0] w_gnt_idx;
  logic [N_REQ-1:0] w_req_ready;
  logic             w_ld;
  logic             w_acc;
  logic             w_last;
  logic [WIDTH-1:0] w_word;

  rr_pick #(.N(N_REQ), .SW(SRC_W)) u_pick (
    .i_req     (bus.req_valid),
    .i_ptr     (r_ptr),
    .o_gnt_oh  (w_gnt_oh),
    .o_gnt_idx (w_gnt_idx)
  );

  assign w_ld   = ~r_link_valid | bus.link_ready;
  assign w_word = bus.req_data[int'(r_grant)*WIDTH +: WIDTH];
  assign w_last = bus.req_last[r_grant];

  // Ready never looks at req_valid, so there is no valid->ready path.
  always_comb begin
    w_req_ready = '0;
    if (r_state == BUSY) w_req_ready[r_grant] = w_ld;
  end

  assign w_acc          = |(w_req_ready & bus.req_valid);
  assign bus.req_ready  = w_req_ready;
  assign bus.link_valid = r_link_valid;
  assign bus.link_data  = r_link_data;
  assign bus.link_last  = r_link_last;
  assign bus.link_src   = r_link_src;

  always_ff @(posedge clock) begin
    if (reset) begin
      r_state      <= IDLE;
      r_ptr        <= SRC_W'(N_REQ - 1);
      r_grant      <= '0;
      r_link_valid <= 1'b0;
      r_link_data  <= '0;
      r_link_last  <= 1'b0;
      r_link_src   <= '0;
    end else begin
      if (w_ld) begin
        r_link_valid <= w_acc;
        if (w_acc) begin
          r_link_data <= w_word;
          r_link_last <= w_last;
          r_link_src  <= r_grant;
        end
      end
      case (r_state)
        IDLE: if (|w_gnt_oh) begin
          r_grant <= w_gnt_idx;
          r_ptr   <= w_gnt_idx;
          r_state <= BUSY;
        end
        BUSY: if (w_acc && w_last) r_state <= IDLE;
      endcase
    end
  end

`ifdef P2P_TX_ARB_STATS_EN
  logic [N_REQ-1:0][STAT_W-1:0] r_stat;

  // Clear has priority over a coincident increment; counts saturate.
  always_ff @(posedge clock) begin
    if (reset || bus.stat_clear) r_stat <= '0;
    else if (w_acc && (r_stat[r_grant] != '1))
      r_stat[r_grant] <= r_stat[r_grant] + STAT_W'(1);
  end

  assign bus.stat_words = r_stat;
`else
  // Counter-free build: nothing further to drive.
`endif
endmodule

// File: tb/tb_p2p_tx_arbiter.sv
// Self-checking bench: directed scenarios plus random traffic against a packet-level model.
module tb_p2p_tx_arbiter;
  localparam int N = 4;
  localparam int W = 8;

  typedef struct {
    logic [W-1:0] d;
    logic         l;
  } word_t;

  logic clock = 1'b0;
  logic reset;
  always #5 clock = ~clock;

  p2p_tx_arbiter_if #(.N_REQ(N), .WIDTH(W)) bus();
  p2p_tx_arbiter #(.N_REQ(N), .WIDTH(W)) dut (.clock(clock), .reset(reset), .bus(bus));

  int n_chk  = 0;
  int n_fail = 0;

  word_t       q[N][$];   // words still to be offered by each requester
  word_t       eq[N][$];  // words each requester must still see on the link
  bit          gap[N];
  bit          started[N];
  int          wcnt[N];
  bit          in_pkt;
  int          cur_src;
  bit          lr_val  = 1'b1;
  bit          lr_rnd  = 1'b0;
  bit          rnd_gap = 1'b0;
  logic [15:0] stat_exp[N];

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] want);
    n_chk++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, want);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  function automatic void clr_model();
    for (int i = 0; i < N; i++) begin
      q[i].delete();
      eq[i].delete();
      gap[i]      = 1'b0;
      started[i]  = 1'b0;
      wcnt[i]     = 0;
      stat_exp[i] = '0;
    end
    in_pkt = 1'b0;
  endfunction

  function automatic bit all_empty();
    for (int i = 0; i < N; i++)
      if (q[i].size() != 0 || eq[i].size() != 0) return 1'b0;
    return 1'b1;
  endfunction

  task automatic do_reset();
    reset = 1'b1;
    clr_model();
    tick();
    tick();
    reset = 1'b0;
  endtask

  task automatic push_pkt(input int r, input int len, input logic [W-1:0] base, input logic [W-1:0] stp);
    word_t w;
    for (int k = 0; k < len; k++) begin
      w.d = base + W'(k) * stp;
      w.l = (k == len - 1);
      q[r].push_back(w);
      eq[r].push_back(w);
    end
  endtask

  task automatic push_rnd(input int r, input int len);
    word_t w;
    for (int k = 0; k < len; k++) begin
      w.d = W'($urandom);
      w.l = (k == len - 1);
      q[r].push_back(w);
      eq[r].push_back(w);
    end
  endtask

  task automatic drain(input int max);
    int k = 0;
    while (!all_empty() && k < max) begin
      tick();
      k++;
    end
    chk("drain", all_empty(), 1'b1);
  endtask

  // Requester drivers, acceptance bookkeeping and link-side scoreboard.
  always @(negedge clock) begin : drv
    bit    v;
    int    acc;
    int    s;
    word_t w;
    for (int i = 0; i < N; i++) begin
      v = (q[i].size() > 0) && !gap[i];
      if (v && rnd_gap && started[i] && ($urandom_range(0, 3) == 0)) v = 1'b0;
      bus.req_valid[i]       = v;
      bus.req_data[i*W +: W] = '0;
      bus.req_last[i]        = 1'b0;
      if (v) begin
        bus.req_data[i*W +: W] = q[i][0].d;
        bus.req_last[i]        = q[i][0].l;
      end
    end
    bus.link_ready = lr_rnd ? ($urandom_range(0, 3) != 0) : lr_val;
    #1;
    acc = 0;
    for (int i = 0; i < N; i++) begin
      if (bus.req_valid[i] && bus.req_ready[i] && q[i].size() > 0) begin
        acc++;
        w = q[i].pop_front();
        if (!started[i]) begin
          chk("starve_bound", wcnt[i] <= N - 1, 1'b1);
          wcnt[i] = 0;
        end
        started[i] = !w.l;
        if (stat_exp[i] != 16'hFFFF) stat_exp[i]++;
        if (w.l)
          for (int k = 0; k < N; k++)
            if (k != i && bus.req_valid[k] && !started[k]) wcnt[k]++;
      end
    end
    if (acc > 0) chk("one_accept", acc <= 1, 1'b1);
    if (bus.link_valid && !bus.link_ready) chk("bp_rdy", bus.req_ready, '0);
    if (bus.link_valid && bus.link_ready) begin
      s = int'(bus.link_src);
      chk("src_range", s < N, 1'b1);
      if (s < N) begin
        chk("exp_word", eq[s].size() > 0, 1'b1);
        if (eq[s].size() > 0) begin
          w = eq[s].pop_front();
          chk("out_data", bus.link_data, w.d);
          chk("out_last", bus.link_last, w.l);
        end
        if (in_pkt) chk("pkt_atomic", s, cur_src);
        in_pkt  = !bus.link_last;
        cur_src = s;
      end
    end
  end

  initial begin
    #3_000_000;
    $display("FAIL watchdog timeout checks=%0d", n_chk);
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1;
`ifdef P2P_TX_ARB_STATS_EN
    bus.stat_clear = 1'b0;
`endif
    do_reset();
    chk("rst_lv",   bus.link_valid, 1'b0);
    chk("rst_ld",   bus.link_data,  '0);
    chk("rst_ll",   bus.link_last,  1'b0);
    chk("rst_src",  bus.link_src,   '0);
    chk("rst_rdy",  bus.req_ready,  '0);

    // Single 3-word packet from requester 2.
    push_pkt(2, 3, 8'h11, 8'h11);
    tick();
    chk("t1_rdy", bus.req_ready, 4'b0100);
    chk("t1_lv0", bus.link_valid, 1'b0);
    for (int w = 0; w < 3; w++) begin
      tick();
      chk("t1_lv",   bus.link_valid, 1'b1);
      chk("t1_data", bus.link_data, 8'h11 * (w + 1));
      chk("t1_src",  bus.link_src, 2);
      chk("t1_last", bus.link_last, w == 2);
    end
    tick();
    chk("t1_idle", bus.link_valid, 1'b0);

    // All requesters busy with 1-word packets: 0,1,2,3,0 with one gap each.
    do_reset();
    for (int r = 0; r < N; r++)
      for (int p = 0; p < 3; p++) push_pkt(r, 1, 8'hA0 + W'(r), 8'h00);
    for (int k = 1; k <= 10; k++) begin
      tick();
      chk("rr_valid", bus.link_valid, (k % 2) == 0);
      if (k % 2 == 0) begin
        chk("rr_src",  bus.link_src, (k / 2 - 1) % N);
        chk("rr_data", bus.link_data, 8'hA0 + ((k / 2 - 1) % N));
      end
    end
    drain(100);

    // Backpressure mid-packet.
    do_reset();
    push_pkt(1, 6, 8'h40, 8'h01);
    repeat (3) tick();
    chk("t3_pre", bus.link_data, 8'h41);
    lr_val = 1'b0;
    repeat (5) begin
      tick();
      chk("t3_hold", bus.link_data, 8'h41);
      chk("t3_rdy",  bus.req_ready, '0);
    end
    lr_val = 1'b1;
    drain(50);

    // Granted requester 1 gaps mid-packet while requester 0 waits.
    do_reset();
    push_pkt(1, 4, 8'h50, 8'h01);
    tick();
    tick();
    gap[1] = 1'b1;
    push_pkt(0, 1, 8'h60, 8'h00);
    repeat (3) begin
      tick();
      chk("t4_rdy", bus.req_ready, 4'b0010);
    end
    gap[1] = 1'b0;
    for (int k = 0; k < 20 && q[1].size() > 0; k++) begin
      tick();
      chk("t4_hold0", bus.req_ready[0], 1'b0);
    end
    drain(50);

    // Reset during requester 3's second word.
    do_reset();
    push_pkt(3, 3, 8'h70, 8'h01);
    tick();
    tick();
    reset = 1'b1;
    tick();
    clr_model();
    chk("t5_lv",  bus.link_valid, 1'b0);
    chk("t5_rdy", bus.req_ready, '0);
    reset = 1'b0;
    push_pkt(3, 1, 8'h78, 8'h00);
    push_pkt(0, 1, 8'h80, 8'h00);
    tick();
    chk("t5_first", bus.req_ready, 4'b0001);
    drain(50);

    // Random traffic, random link stalls and mid-packet gaps.
    do_reset();
    lr_rnd  = 1'b1;
    rnd_gap = 1'b1;
    repeat (800) begin
      if ($urandom_range(0, 2) == 0) begin
        int r;
        r = $urandom_range(0, N - 1);
        if (q[r].size() < 8) push_rnd(r, $urandom_range(1, 4));
      end
      tick();
    end
    lr_rnd  = 1'b0;
    rnd_gap = 1'b0;
    lr_val  = 1'b1;
    drain(500);

`ifdef P2P_TX_ARB_STATS_EN
    for (int i = 0; i < N; i++) chk("stat_cnt", bus.stat_words[i*16 +: 16], stat_exp[i]);

    do_reset();
    push_pkt(2, 3, 8'h90, 8'h01);
    tick();
    tick();
    chk("st_one", bus.stat_words[32 +: 16], 16'd1);
    bus.stat_clear = 1'b1;
    tick();
    bus.stat_clear = 1'b0;
    stat_exp[2] = '0;
    chk("st_clr_wins", bus.stat_words[32 +: 16], 16'd0);
    drain(50);
    chk("st_after", bus.stat_words[32 +: 16], stat_exp[2]);

    push_pkt(1, 70000, 8'h00, 8'h01);
    drain(71000);
    chk("st_sat",   bus.stat_words[16 +: 16], 16'hFFFF);
    chk("st_model", bus.stat_words[16 +: 16], stat_exp[1]);
    bus.stat_clear = 1'b1;
    tick();
    bus.stat_clear = 1'b0;
    chk("st_clr", bus.stat_words[16 +: 16], 16'd0);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/p2p_tx_arbiter.md
# p2p_tx_arbiter

Round-robin packet arbiter that shares one outgoing point-to-point link between `N_REQ` local requesters. It sits between on-host producers and a `point_master_io` link instance: its link-side outputs drive the link's `data_o` fields, and `link_ready` comes back from the link's `data_i` response bit. Arbitration is per packet: a granted requester keeps the link until its `last` word is accepted, then the grant rotates.

## Interface
- `N_REQ`, 4: number of requesters, 2..16.
- `WIDTH`, 8: payload width per word.
- `SRC_W`, derived: `max(1, clog2(N_REQ))`, width of the source tag.
- `clock`  in  1  single clock; all logic on the rising edge.
- `reset`  in  1  synchronous, active-high.
- `req_valid`  in  N_REQ  per-requester word valid.
- `req_data`  in  N_REQ*WIDTH  requester i occupies bits [i*WIDTH +: WIDTH].
- `req_last`  in  N_REQ  word is the final word of its packet.
- `req_ready`  out  N_REQ  word accepted this cycle when `req_valid[i] & req_ready[i]`.
- `link_valid`  out  1  registered output word valid.
- `link_data`  out  WIDTH  registered payload.
- `link_last`  out  1  registered end-of-packet flag.
- `link_src`  out  SRC_W  index of the requester that sourced the word.
- `link_ready`  in  1  link accepts the output word this cycle.
- `stat_clear`  in  1  present only with `P2P_TX_ARB_STATS_EN`.
- `stat_words`  out  N_REQ*16  present only with `P2P_TX_ARB_STATS_EN`.

## Operation
- Reset values: `link_valid`=0, `link_data`=0, `link_last`=0, `link_src`=0, `req_ready`=0, state IDLE, round-robin pointer `N_REQ-1` (requester 0 wins first), stats counters 0.
- Output register load enable: `ld = ~link_valid | link_ready`.
- State IDLE:
  - `req_ready` is all zero.
  - If any `req_valid` is high, pick the first valid requester scanning from pointer+1 with wrap-around.
  - Latch it as `grant`, set the pointer to `grant`, and go to BUSY.
  - Otherwise stay in IDLE.
- State BUSY:
  - `req_ready[grant] = ld`; every other bit is 0.
  - On acceptance: `link_data`/`link_last` take the granted requester's word, `link_src` takes `grant`, and `link_valid` is set to 1.
  - On acceptance with `req_last` high, return to IDLE.
  - When `ld` is high and no word is accepted, clear `link_valid` to 0.
- Requests from non-granted requesters are ignored until the current packet ends. No requester can be starved: each is at most N_REQ-1 packets from a grant.
- A requester that drops `req_valid` mid-packet keeps the grant; the link idles until it resumes.
- Reset mid-packet:
  - Any word in the output register is dropped.
  - The partial packet is abandoned with no `link_last` emitted.
  - The pointer returns to `N_REQ-1`.

## Timing
- Arbitration latency: 1 cycle. A request seen in IDLE at edge k gives `req_ready` high in the cycle after edge k.
- Data latency: a word accepted at edge k appears on `link_*` after edge k.
- Throughput: 1 word per cycle within a packet while `link_ready` stays high.
- Each packet boundary costs exactly one idle cycle (the IDLE state).
- Backpressure: while `link_valid & ~link_ready`, all `link_*` outputs hold stable and `req_ready` is 0.
- `req_ready` is combinational from `link_ready`, state and `grant`. There is no combinational path from `req_valid` to `req_ready`.

## Configuration
- `P2P_TX_ARB_STATS_EN` defined:
  - Adds one 16-bit word counter per requester, incremented on each accepted word.
  - Counters saturate at 16'hFFFF.
  - `stat_clear` zeroes all counters on the next edge. If clear and an increment coincide, clear wins.
  - The counters drive `stat_words`.
- `P2P_TX_ARB_STATS_EN` undefined: the counters and both `stat_*` ports are absent; all other behaviour is identical.

## Structure
- Package `p2p_tx_arb_pkg`:
  - State enum `{IDLE, BUSY}`.
  - `STAT_W = 16`.
  - Function `src_width(n)` returning `max(1, clog2(n))`.
- Sub-module `rr_pick`: combinational round-robin picker. Inputs are the request vector and the pointer; outputs are a one-hot grant and its index.
- The state machine, output register and optional counters live in the top module.

## Test plan
- Single packet: requester 2 sends 3 words 8'h11, 8'h22, 8'h33 (last on the third) with `link_ready`=1 -> `link_data` shows 11, 22, 33 on consecutive cycles, `link_src`=2, `link_last` only on 33, first word 2 cycles after `req_valid` rises.
- Round robin: all 4 requesters hold 1-word packets continuously -> grant order 0, 1, 2, 3, 0 with exactly one idle cycle between packets.
- Backpressure: hold `link_ready`=0 for 5 cycles mid-packet -> `link_data` stays constant, `req_ready`=0 throughout, no word lost or duplicated after release.
- Gapped packet: granted requester 1 drops `req_valid` for 3 cycles mid-packet while requester 0 is valid -> requester 0 gets no `req_ready` until requester 1's last word is accepted.
- Reset mid-packet: assert `reset` one cycle during requester 3's second word -> next cycle `link_valid`=0, state IDLE; requester 0 is granted first afterwards.
- Stats (with `P2P_TX_ARB_STATS_EN`): 70000 words from requester 1 -> `stat_words[31:16]`=16'hFFFF; `stat_clear` pulse -> 0 on the next edge.
